// File: rtl/serial_frame_tx.sv
// serial_frame_tx: parallel-to-serial frame transmitter (start bit, MSB-first data, optional even parity)
module serial_frame_tx #(
  parameter int WIDTH = 4,
  parameter int BIT_CYCLES = 1,
  parameter int PARITY_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  output logic             dout,
  output logic             dout_data,
  output logic             busy,
  output logic             frame_done
);
  typedef enum logic [1:0] {IDLE, START, DATA, PARITY} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic par_q, par_d;
  logic [7:0] div_q, div_d;
  logic [4:0] bit_q, bit_d;
  logic dout_q, dout_data_q, busy_q, done_q;
  logic dout_d, dout_data_d, busy_d, done_d;
  logic bit_end, last_data;
  assign bit_end = div_q == 8'(BIT_CYCLES - 1);
  assign last_data = bit_q == 5'(WIDTH - 1);
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    par_d = par_q;
    div_d = div_q;
    bit_d = bit_q;
    if (state_q == IDLE) begin
      if (in_valid) begin
        state_d = START;
        shreg_d = in_data;
        par_d = ^in_data;
        div_d = '0;
        bit_d = '0;
      end
    end else if (flush) begin
      state_d = IDLE;
      shreg_d = '0;
      par_d = 1'b0;
      div_d = '0;
      bit_d = '0;
    end else if (!bit_end) begin
      div_d = div_q + 8'd1;
    end else begin
      div_d = '0;
      if (state_q == START) begin
        state_d = DATA;
      end else if (state_q == DATA) begin
        shreg_d = shreg_q << 1;
        bit_d = last_data ? bit_q : bit_q + 5'd1;
        if (last_data) state_d = (PARITY_EN != 0) ? PARITY : IDLE;
      end else begin
        state_d = IDLE;
      end
    end
  end
  // Outputs are decoded from the next state so they can be registered without a cycle of lag.
  assign dout_d = state_d == START ? 1'b1 : state_d == DATA ? shreg_d[WIDTH-1] : state_d == PARITY && par_d;
  assign dout_data_d = state_d == DATA;
  assign busy_d = state_d != IDLE;
  assign done_d = div_d == 8'(BIT_CYCLES - 1) &&
                  (state_d == PARITY || (PARITY_EN == 0 && state_d == DATA && bit_d == 5'(WIDTH - 1)));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      par_q <= 1'b0;
      div_q <= '0;
      bit_q <= '0;
      dout_q <= 1'b0;
      dout_data_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      par_q <= par_d;
      div_q <= div_d;
      bit_q <= bit_d;
      dout_q <= dout_d;
      dout_data_q <= dout_data_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end
  assign in_ready = state_q == IDLE && !rst;
  assign dout = dout_q;
  assign dout_data = dout_data_q;
  assign busy = busy_q;
  assign frame_done = done_q;
endmodule

// File: tb/tb_serial_frame_tx.sv
// tb_serial_frame_tx: scoreboard bench over two configurations of serial_frame_tx
module tb_serial_frame_tx;
  localparam int W = 4;
  typedef struct {
    logic [W-1:0] d;
    int fl;
  } txn_t;
  logic clk = 1'b0;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  task automatic chk(input int g, input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL cfg%0d %s: got %0d expected %0d at %0t", g, name, act, exp, $time);
    end
  endtask
  for (genvar g = 0; g < 2; g++) begin : cfg
    localparam int BC = g ? 3 : 1;
    localparam int PE = g ? 0 : 1;
    localparam int LEN = (1 + W + PE) * BC;
    logic rst, in_valid, flush, in_ready, dout, dout_data, busy, frame_done;
    logic [W-1:0] in_data;
    bit started = 0;
    bit mon_stop = 0;
    bit done = 0;
    txn_t q[$];
    serial_frame_tx #(.WIDTH(W), .BIT_CYCLES(BC), .PARITY_EN(PE)) dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .flush(flush), .dout(dout), .dout_data(dout_data), .busy(busy), .frame_done(frame_done)
    );
    // Reference: clock i of a frame carries bit i/BC of {start, data MSB-first, parity}.
    function automatic void exp_at(input logic [W-1:0] d, input int i, output logic o, output logic dd);
      int b;
      b = i / BC;
      o = b == 0 ? 1'b1 : b <= W ? d[W-b] : ^d;
      dd = b >= 1 && b <= W;
    endfunction
    initial begin
      txn_t t;
      logic eo, ed;
      int last;
      wait (started);
      forever begin
        @(negedge clk);
        if (mon_stop) break;
        if (!busy) begin
          chk(g, "idle {dout,dout_data,frame_done,in_ready}", int'({dout, dout_data, frame_done, in_ready}), 1);
        end else begin
          chk(g, "frame expected", q.size() > 0, 1);
          if (q.size() > 0) begin
            t = q.pop_front();
            last = t.fl >= 0 ? t.fl : LEN - 1;
            for (int i = 0; i <= last; i++) begin
              if (i != 0) @(negedge clk);
              exp_at(t.d, i, eo, ed);
              chk(g, "dout", int'(dout), int'(eo));
              chk(g, "dout_data", int'(dout_data), int'(ed));
              chk(g, "busy", int'(busy), 1);
              chk(g, "frame_done", int'(frame_done), int'(i == LEN - 1));
              chk(g, "in_ready busy", int'(in_ready), 0);
            end
          end
        end
      end
    end
    initial begin
      logic [W-1:0] plan [5];
      int pfl [5];
      txn_t t;
      int gap, w;
      plan[0] = 4'b1011; plan[1] = 4'b0110; plan[2] = 4'b1111; plan[3] = 4'b1011; plan[4] = 4'b0001;
      pfl[0] = -1; pfl[1] = -1; pfl[2] = -1; pfl[3] = 2 * BC; pfl[4] = -1;
      rst = 1'b1; in_valid = 1'b0; flush = 1'b0; in_data = '0;
      repeat (2) @(negedge clk);
      chk(g, "reset outputs", int'({dout, dout_data, busy, frame_done, in_ready}), 0);
      rst = 1'b0;
      started = 1;
      for (int n = 0; n < 45; n++) begin
        t.d = n < 5 ? plan[n] : W'($urandom);
        t.fl = n < 5 ? pfl[n] : ($urandom_range(0, 3) == 0 ? int'($urandom_range(0, LEN - 2)) : -1);
        gap = n < 5 ? 0 : int'($urandom_range(0, 2));
        @(negedge clk);
        flush = 1'b0;
        repeat (gap) begin
          in_valid = 1'b0;
          flush = 1'($urandom_range(0, 1));
          in_data = W'($urandom);
          @(negedge clk);
        end
        w = 0;
        while (!in_ready && w < 50) begin
          @(negedge clk);
          w++;
        end
        chk(g, "in_ready before issue", int'(in_ready), 1);
        in_data = t.d;
        in_valid = 1'b1;
        flush = n >= 5 && $urandom_range(0, 3) == 0;
        q.push_back(t);
        @(posedge clk);
        for (int i = 0; i < LEN; i++) begin
          @(negedge clk);
          in_data = W'($urandom);
          in_valid = n < 5 ? 1'b1 : 1'($urandom_range(0, 1));
          flush = i == t.fl;
          if (i == t.fl) break;
        end
      end
      @(negedge clk);
      flush = 1'b0;
      in_valid = 1'b0;
      repeat (LEN + 3) @(negedge clk);
      chk(g, "scoreboard drained", q.size(), 0);
      mon_stop = 1;
      repeat (2) @(negedge clk);
      in_data = 4'b1011;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      in_data = '0;
      @(posedge clk);
      #2;
      chk(g, "pre-reset dout", int'(dout), 1);
      chk(g, "pre-reset busy", int'(busy), 1);
      rst = 1'b1;
      #1;
      chk(g, "async reset outputs", int'({dout, dout_data, busy, frame_done, in_ready}), 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (LEN + 2) begin
        @(negedge clk);
        chk(g, "post-reset idle", int'({dout, dout_data, busy, frame_done, in_ready}), 1);
      end
      done = 1;
    end
  end
  initial begin
    int w = 0;
    while (!(cfg[0].done && cfg[1].done) && w < 20000) begin
      @(posedge clk);
      w++;
    end
    chk(-1, "bench completion", int'(cfg[0].done && cfg[1].done), 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
